fp_round_pack: RTL and testbench

//  Consumer end of the FP adder result interface. Accepts the adder's unrounded

---
 rtl/fp_round_pack.sv | 190 +++++++++++++++++++
 tb/tb_fp_round_pack.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_round_pack.sv
// fp_round_pack: normalize, round and pack an unrounded adder sum into binary64, 3-stage valid/ready pipe.
// Build option: define ROUND_FLUSH_DENORM_EN to flush subnormal results to signed zero.
module fp_round_pack #(
  parameter int EW = 11,
  parameter int FW = 52
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [EW-1:0]  in_es,
  input  logic [FW+4:0]  in_fs,
  input  logic           in_ss,
  input  logic [1:0]     in_fls,
  input  logic           in_nan,
  input  logic [FW-1:0]  in_nan_frac,
  input  logic [1:0]     in_rm,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [EW+FW:0] out_result,
  output logic [2:0]     out_exc
);

  localparam int MW  = FW + 4;
  localparam int LZW = $clog2(MW + 1);
  localparam logic [EW:0] EXP_ONE = {{EW{1'b0}}, 1'b1};
  localparam logic [EW:0] EXP_OVF = {1'b0, {EW{1'b1}}};

  function automatic logic [LZW-1:0] lead_zeros(input logic [MW-1:0] v);
    logic [LZW-1:0] n;
    n = LZW'(MW);
    for (int i = 0; i < MW; i++) begin
      n = v[i] ? LZW'(MW - 1 - i) : n;
    end
    return n;
  endfunction

  logic           stall_s;
  logic [EW-1:0]  e_eff_s, e_m1_s;
  logic [LZW-1:0] lz_s, sh_s;
  logic [MW-1:0]  m_norm_s;
  logic [EW:0]    exp_norm_s;

  logic           v1_r, ss1_r, nan1_r;
  logic [MW-1:0]  m1_r;
  logic [EW:0]    exp1_r;
  logic [1:0]     fls1_r, rm1_r;
  logic [FW-1:0]  nf1_r;

  logic           inc_s, grs_s;
  logic [FW+1:0]  sum_s;
  logic [FW-1:0]  frac_rnd_s;
  logic [EW:0]    exp_rnd_s;

  logic           v2_r, ss2_r, nan2_r, tiny2_r, inx2_r, zero2_r;
  logic [FW-1:0]  frac2_r, nf2_r;
  logic [EW:0]    exp2_r;
  logic [1:0]     fls2_r, rm2_r;

  logic           to_inf_s;
  logic [EW+FW:0] pack_s;
  logic [2:0]     exc_s;

  logic           out_valid_r;
  logic [EW+FW:0] result_r;
  logic [2:0]     exc_r;

  assign stall_s    = out_valid_r & ~out_ready;
  assign in_ready   = ~stall_s;
  assign out_valid  = out_valid_r;
  assign out_result = result_r;
  assign out_exc    = exc_r;

  // Stage 1: carry right-shift, or left-normalize limited so the exponent never drops below 1
  always_comb begin
    e_eff_s = (in_es == {EW{1'b0}}) ? {{(EW-1){1'b0}}, 1'b1} : in_es;
    e_m1_s  = e_eff_s - {{(EW-1){1'b0}}, 1'b1};
    lz_s    = lead_zeros(in_fs[MW-1:0]);
    sh_s    = ({{(EW-LZW){1'b0}}, lz_s} < e_m1_s) ? lz_s : LZW'(e_m1_s);
    if (in_fs[MW]) begin
      m_norm_s   = {in_fs[MW:2], |in_fs[1:0]};
      exp_norm_s = {1'b0, e_eff_s} + EXP_ONE;
    end else begin
      m_norm_s   = in_fs[MW-1:0] << sh_s;
      exp_norm_s = {1'b0, e_eff_s} - {{(EW+1-LZW){1'b0}}, sh_s};
    end
  end

  // Stage 2: rounding increment on the 53-bit significand; hidden bit decides the exponent field
  always_comb begin
    grs_s = m1_r[2] | m1_r[1] | m1_r[0];
    case (rm1_r)
      2'b00:   inc_s = m1_r[2] & (m1_r[1] | m1_r[0] | m1_r[3]);
      2'b01:   inc_s = 1'b0;
      2'b10:   inc_s = ~ss1_r & grs_s;
      2'b11:   inc_s = ss1_r & grs_s;
      default: inc_s = 1'b0;
    endcase
    sum_s = {1'b0, m1_r[MW-1:3]} + {{(FW+1){1'b0}}, inc_s};
    if (sum_s[FW+1]) begin
      frac_rnd_s = {FW{1'b0}};
      exp_rnd_s  = exp1_r + EXP_ONE;
    end else if (sum_s[FW]) begin
      frac_rnd_s = sum_s[FW-1:0];
      exp_rnd_s  = exp1_r;
    end else begin
      frac_rnd_s = sum_s[FW-1:0];
      exp_rnd_s  = {(EW+1){1'b0}};
    end
  end

  // Stage 3: special-value priority and exception flags
  always_comb begin
    to_inf_s = (rm2_r == 2'b00) | ((rm2_r == 2'b10) & ~ss2_r) | ((rm2_r == 2'b11) & ss2_r);
    if (nan2_r) begin
      pack_s = {ss2_r, {EW{1'b1}}, nf2_r | {1'b1, {(FW-1){1'b0}}}};
      exc_s  = 3'b000;
    end else if (fls2_r[1]) begin
      pack_s = {ss2_r, {EW{1'b1}}, {FW{1'b0}}};
      exc_s  = 3'b000;
    end else if (fls2_r[0] | zero2_r) begin
      pack_s = {ss2_r, {(EW+FW){1'b0}}};
      exc_s  = 3'b000;
    end else if (exp2_r >= EXP_OVF) begin
      pack_s = to_inf_s ? {ss2_r, {EW{1'b1}}, {FW{1'b0}}}
                        : {ss2_r, {(EW-1){1'b1}}, 1'b0, {FW{1'b1}}};
      exc_s  = 3'b101;
`ifdef ROUND_FLUSH_DENORM_EN
    end else if ((exp2_r == {(EW+1){1'b0}}) && (frac2_r != {FW{1'b0}})) begin
      pack_s = {ss2_r, {(EW+FW){1'b0}}};
      exc_s  = 3'b011;
`endif
    end else begin
      pack_s = {ss2_r, exp2_r[EW-1:0], frac2_r};
      exc_s  = {1'b0, tiny2_r & inx2_r, inx2_r};
    end
  end

  // Pipeline registers: whole pipe advances together unless the output is stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_r        <= 1'b0;
      m1_r        <= {MW{1'b0}};
      exp1_r      <= {(EW+1){1'b0}};
      ss1_r       <= 1'b0;
      fls1_r      <= 2'b00;
      nan1_r      <= 1'b0;
      nf1_r       <= {FW{1'b0}};
      rm1_r       <= 2'b00;
      v2_r        <= 1'b0;
      frac2_r     <= {FW{1'b0}};
      exp2_r      <= {(EW+1){1'b0}};
      tiny2_r     <= 1'b0;
      inx2_r      <= 1'b0;
      zero2_r     <= 1'b0;
      ss2_r       <= 1'b0;
      fls2_r      <= 2'b00;
      nan2_r      <= 1'b0;
      nf2_r       <= {FW{1'b0}};
      rm2_r       <= 2'b00;
      out_valid_r <= 1'b0;
      result_r    <= {(EW+FW+1){1'b0}};
      exc_r       <= 3'b000;
    end else if (!stall_s) begin
      v1_r        <= in_valid;
      m1_r        <= m_norm_s;
      exp1_r      <= exp_norm_s;
      ss1_r       <= in_ss;
      fls1_r      <= in_fls;
      nan1_r      <= in_nan;
      nf1_r       <= in_nan_frac;
      rm1_r       <= in_rm;
      v2_r        <= v1_r;
      frac2_r     <= frac_rnd_s;
      exp2_r      <= exp_rnd_s;
      tiny2_r     <= ~m1_r[MW-1];
      inx2_r      <= grs_s;
      zero2_r     <= (m1_r == {MW{1'b0}});
      ss2_r       <= ss1_r;
      fls2_r      <= fls1_r;
      nan2_r      <= nan1_r;
      nf2_r       <= nf1_r;
      rm2_r       <= rm1_r;
      out_valid_r <= v2_r;
      result_r    <= pack_s;
      exc_r       <= exc_s;
    end
  end

endmodule

// File: tb/tb_fp_round_pack.sv
// Self-checking bench for fp_round_pack: directed vectors, stall/back-to-back, mid-stream reset, random stream.
module tb_fp_round_pack;

  typedef struct packed {
    logic [56:0] fs;
    logic [10:0] es;
    logic        ss;
    logic [1:0]  fls;
    logic        nan;
    logic [51:0] nf;
    logic [1:0]  rm;
  } stim_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [10:0] in_es;
  logic [56:0] in_fs;
  logic        in_ss;
  logic [1:0]  in_fls;
  logic        in_nan;
  logic [51:0] in_nan_frac;
  logic [1:0]  in_rm;
  logic        out_valid, out_ready;
  logic [63:0] out_result;
  logic [2:0]  out_exc;

  int checks = 0;
  int failures = 0;
  logic [66:0] exp_q[$];

  always #5 clk = ~clk;

  fp_round_pack dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_es(in_es), .in_fs(in_fs), .in_ss(in_ss), .in_fls(in_fls),
    .in_nan(in_nan), .in_nan_frac(in_nan_frac), .in_rm(in_rm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_exc(out_exc)
  );

  // Reference: exact value fs * 2^(e-1023-55) rounded to binary64 with integer arithmetic.
  function automatic logic [66:0] ref_model(input stim_t t);
    int e, p, eb, lsb, expf;
    logic [127:0] big, kept, rem, half;
    logic inexact, up, tiny;
    if (t.nan) return {3'b000, t.ss, 11'h7FF, 1'b1, t.nf[50:0]};
    if (t.fls[1]) return {3'b000, t.ss, 11'h7FF, 52'd0};
    if (t.fls[0] || t.fs == 57'd0) return {3'b000, t.ss, 63'd0};
    e = (t.es == 11'd0) ? 1 : int'(t.es);
    p = 0;
    for (int i = 0; i < 57; i++) if (t.fs[i]) p = i;
    eb = e + p - 55;
    tiny = (eb < 1);
    if (tiny) eb = 1;
    lsb = 3 + eb - e;
    big = {71'd0, t.fs};
    if (lsb >= 0) begin
      kept = big >> lsb;
      rem  = big & ((128'd1 << lsb) - 128'd1);
      half = (lsb == 0) ? 128'd0 : (128'd1 << (lsb - 1));
    end else begin
      kept = big << (-lsb);
      rem  = 128'd0;
      half = 128'd0;
    end
    inexact = (rem != 128'd0);
    case (t.rm)
      2'd0:    up = (rem > half) || (inexact && rem == half && kept[0]);
      2'd1:    up = 1'b0;
      2'd2:    up = !t.ss && inexact;
      default: up = t.ss && inexact;
    endcase
    if (up) kept = kept + 128'd1;
    if (kept == (128'd1 << 53)) begin
      kept = 128'd1 << 52;
      eb = eb + 1;
    end
    if (eb >= 2047) begin
      if (t.rm == 2'd0 || (t.rm == 2'd2 && !t.ss) || (t.rm == 2'd3 && t.ss))
        return {3'b101, t.ss, 11'h7FF, 52'd0};
      return {3'b101, t.ss, 11'h7FE, {52{1'b1}}};
    end
    expf = (kept < (128'd1 << 52)) ? 0 : eb;
`ifdef ROUND_FLUSH_DENORM_EN
    if (expf == 0 && kept[51:0] != 52'd0) return {3'b011, t.ss, 63'd0};
`endif
    return {1'b0, tiny && inexact, inexact, t.ss, expf[10:0], kept[51:0]};
  endfunction

  function automatic stim_t mk(input logic [56:0] fs, input logic [10:0] es, input logic ss,
                               input logic [1:0] fls, input logic nan, input logic [51:0] nf,
                               input logic [1:0] rm);
    stim_t t;
    t.fs = fs; t.es = es; t.ss = ss; t.fls = fls; t.nan = nan; t.nf = nf; t.rm = rm;
    return t;
  endfunction

  function automatic stim_t rand_stim();
    stim_t t;
    logic [63:0] r;
    r = {$urandom, $urandom};
    if ($urandom_range(0, 9) < 3) t.fs = {1'b1, r[55:0]};
    else t.fs = {1'b0, r[55:0] >> $urandom_range(0, 56)};
    if ($urandom_range(0, 3) == 0) t.fs[2:0] = 3'b100;
    case ($urandom_range(0, 3))
      0:       t.es = 11'($urandom_range(0, 60));
      1:       t.es = 11'($urandom_range(1990, 2047));
      default: t.es = 11'($urandom_range(0, 2047));
    endcase
    t.ss  = 1'($urandom);
    t.rm  = 2'($urandom);
    t.fls = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(1, 2)) : 2'b00;
    t.nan = ($urandom_range(0, 31) == 0);
    t.nf  = 52'({$urandom, $urandom});
    return t;
  endfunction

  task automatic apply(input stim_t t);
    in_fs = t.fs; in_es = t.es; in_ss = t.ss; in_fls = t.fls;
    in_nan = t.nan; in_nan_frac = t.nf; in_rm = t.rm;
  endtask

  task automatic send_one(input stim_t t, output logic [63:0] res, output logic [2:0] exc, output int lat);
    @(negedge clk);
    apply(t);
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    res = out_result;
    exc = out_exc;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    apply(mk(57'd0, 11'd0, 1'b0, 2'b00, 1'b0, 52'd0, 2'b00));
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got %b want 0", out_valid); end
    checks++; if (out_result !== 64'd0) begin failures++; $display("FAIL reset_result got %h want 0", out_result); end
    checks++; if (out_exc !== 3'b000) begin failures++; $display("FAIL reset_exc got %b want 000", out_exc); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_directed();
    stim_t v[12];
    logic [63:0] er[12];
    logic [2:0] ee[12];
    logic [63:0] res;
    logic [2:0] exc;
    int lat;
    v[0]  = mk(57'd1 << 55, 11'd1023, 1'b0, 2'b00, 1'b0, 52'd0, 2'b00);
    er[0] = 64'h3FF0_0000_0000_0000; ee[0] = 3'b000;
    v[1]  = mk({1'b0, {53{1'b1}}, 3'b100}, 11'd1023, 1'b0, 2'b00, 1'b0, 52'd0, 2'b00);
    er[1] = 64'h4000_0000_0000_0000; ee[1] = 3'b001;
    v[2]  = mk(57'd1 << 56, 11'd2046, 1'b0, 2'b00, 1'b0, 52'd0, 2'b01);
    er[2] = 64'h7FEF_FFFF_FFFF_FFFF; ee[2] = 3'b101;
    v[3]  = mk(57'd1 << 56, 11'd2046, 1'b0, 2'b00, 1'b0, 52'd0, 2'b00);
    er[3] = 64'h7FF0_0000_0000_0000; ee[3] = 3'b101;
    v[4]  = mk(57'd1 << 54, 11'd1, 1'b0, 2'b00, 1'b0, 52'd0, 2'b00);
    v[5]  = mk(57'd1 << 55, 11'd1023, 1'b1, 2'b01, 1'b0, 52'd0, 2'b11);
    er[5] = 64'h8000_0000_0000_0000; ee[5] = 3'b000;
    v[6]  = mk(57'd1 << 55, 11'd1023, 1'b1, 2'b00, 1'b1, 52'h0_0000_0000_ABCD, 2'b00);
    er[6] = 64'hFFF8_0000_0000_ABCD; ee[6] = 3'b000;
    v[7]  = mk(57'd1 << 55, 11'd1023, 1'b0, 2'b10, 1'b0, 52'd0, 2'b00);
    er[7] = 64'h7FF0_0000_0000_0000; ee[7] = 3'b000;
    v[8]  = mk(57'd1 << 55, 11'd0, 1'b0, 2'b00, 1'b0, 52'd0, 2'b00);
    er[8] = 64'h0010_0000_0000_0000; ee[8] = 3'b000;
    v[9]  = mk((57'd1 << 55) | 57'd1, 11'd1023, 1'b1, 2'b00, 1'b0, 52'd0, 2'b10);
    er[9] = 64'hBFF0_0000_0000_0000; ee[9] = 3'b001;
    v[10] = mk((57'd1 << 55) | 57'd1, 11'd1023, 1'b1, 2'b00, 1'b0, 52'd0, 2'b11);
    er[10] = 64'hBFF0_0000_0000_0001; ee[10] = 3'b001;
    v[11] = mk((57'd1 << 52) | 57'd4, 11'd1, 1'b0, 2'b00, 1'b0, 52'd0, 2'b00);
`ifdef ROUND_FLUSH_DENORM_EN
    er[4] = 64'h0; ee[4] = 3'b011;
    er[11] = 64'h0; ee[11] = 3'b011;
`else
    er[4] = 64'h0008_0000_0000_0000; ee[4] = 3'b000;
    er[11] = 64'h0002_0000_0000_0000; ee[11] = 3'b011;
`endif
    for (int i = 0; i < 12; i++) begin
      send_one(v[i], res, exc, lat);
      checks++; if (res !== er[i]) begin failures++; $display("FAIL directed%0d_result got %h want %h", i, res, er[i]); end
      checks++; if (exc !== ee[i]) begin failures++; $display("FAIL directed%0d_exc got %b want %b", i, exc, ee[i]); end
      checks++; if (lat != 3) begin failures++; $display("FAIL directed%0d_latency got %0d want 3", i, lat); end
    end
  endtask

  task automatic test_back_to_back();
    stim_t v[6];
    logic [66:0] exp_v, held;
    logic held_ok;
    int sent, got, stall_cnt, cyc;
    for (int i = 0; i < 6; i++) v[i] = rand_stim();
    exp_q.delete();
    sent = 0; got = 0; stall_cnt = 0; cyc = 0; held_ok = 1'b0; held = 67'd0;
    while ((sent < 6 || got < 6) && cyc < 60) begin
      @(negedge clk);
      out_ready = !(cyc >= 4 && cyc <= 6);
      #1;
      if (held_ok) begin
        checks++;
        if ({out_exc, out_result} !== held) begin failures++; $display("FAIL b2b_hold got %h want %h", {out_exc, out_result}, held); end
      end
      checks++;
      if (in_ready !== !(out_valid && !out_ready)) begin failures++; $display("FAIL b2b_in_ready got %b at cycle %0d", in_ready, cyc); end
      if (!in_ready) stall_cnt++;
      held_ok = out_valid && !out_ready;
      held = {out_exc, out_result};
      if (out_valid && out_ready) begin
        got++;
        checks++;
        if (exp_q.size() == 0) begin failures++; $display("FAIL b2b_extra got %h want nothing", out_result); end
        else begin
          exp_v = exp_q.pop_front();
          if ({out_exc, out_result} !== exp_v) begin failures++; $display("FAIL b2b_data got %h want %h", {out_exc, out_result}, exp_v); end
        end
      end
      if (sent < 6) begin
        apply(v[sent]);
        in_valid = 1'b1;
        if (in_ready) begin exp_q.push_back(ref_model(v[sent])); sent++; end
      end else in_valid = 1'b0;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++; if (got != 6 || exp_q.size() != 0) begin failures++; $display("FAIL b2b_count got %0d want 6", got); end
    checks++; if (stall_cnt != 3) begin failures++; $display("FAIL b2b_stall_cycles got %0d want 3", stall_cnt); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      apply(rand_stim());
      in_valid = 1'b1;
    end
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL midrst_pre_valid got %b want 1", out_valid); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid got %b want 0", out_valid); end
    checks++; if (out_result !== 64'd0) begin failures++; $display("FAIL midrst_result got %h want 0", out_result); end
    rst = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_stale got %b want 0 at cycle %0d", out_valid, i); end
    end
  endtask

  task automatic test_random();
    stim_t t;
    logic [66:0] exp_v;
    int sent, got, cyc;
    exp_q.delete();
    sent = 0; got = 0; cyc = 0;
    t = rand_stim();
    while ((sent < 400 || got < 400) && cyc < 4000) begin
      @(negedge clk);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      checks++;
      if (in_ready !== !(out_valid && !out_ready)) begin failures++; $display("FAIL rand_in_ready got %b at cycle %0d", in_ready, cyc); end
      if (out_valid && out_ready) begin
        got++;
        checks++;
        if (exp_q.size() == 0) begin failures++; $display("FAIL rand_extra got %h want nothing", out_result); end
        else begin
          exp_v = exp_q.pop_front();
          if ({out_exc, out_result} !== exp_v) begin failures++; $display("FAIL rand_data got %h want %h", {out_exc, out_result}, exp_v); end
        end
      end
      if (sent < 400 && $urandom_range(0, 4) != 0) begin
        apply(t);
        in_valid = 1'b1;
        if (in_ready) begin exp_q.push_back(ref_model(t)); sent++; t = rand_stim(); end
      end else in_valid = 1'b0;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++; if (got != 400 || exp_q.size() != 0) begin failures++; $display("FAIL rand_count got %0d want 400", got); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
